// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and later round stages.
//   word_t / block_t : 32-bit word and 128-bit block types
//   state_t          : key-expansion FSM states
//   SBOX / sbox()    : forward S-box table and byte lookup
//   RCON             : round constants, indexed by round number (1..10)
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Element 0 is the leftmost entry.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Padded to 16 entries so any 4-bit round number is a legal index.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel forward S-box lookups.
//   word_i : input word
//   word_o : each byte of word_i replaced by its S-box image
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  always_comb begin
    word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
              sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule, one round key per clock.
//   clk, rst      : clock, synchronous active-low reset
//   start, key    : rising edge of start in IDLE loads key and begins expansion
//   round_key/idx : current round key (w0 in [127:96]) and its index 0..10
//   rk_valid      : round_key/round_idx valid
//   finish        : one-cycle pulse with round_idx == 10
//   busy          : high from accepted start until finish has been emitted
//   rd_idx/rd_key : round-key store read port (AES_KEY_STORE_EN), else rd_key = 0
// Optional feature macro: AES_KEY_STORE_EN
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         finish,
  output logic         busy,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  state_t state_q, state_d;
  logic   start_q, start_d;
  block_t rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic   valid_q, valid_d;
  logic   fin_q, fin_d;
  logic   busy_q, busy_d;

  logic   accept;
  logic   last;
  word_t  rot_w3, sub_w3;
  word_t  w0_n, w1_n, w2_n, w3_n;

  assign accept = start & ~start_q & (state_q == IDLE);
  assign last   = (idx_q == 4'(NROUNDS));

  // RotWord: bytes {b1,b2,b3,b0} with b0 the most significant byte of w3.
  assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

  aes_sub_word u_sub_word (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  always_comb begin
    w0_n = rk_q[127:96] ^ sub_w3 ^ {RCON[idx_q + 4'd1], 24'h0};
    w1_n = rk_q[95:64]  ^ w0_n;
    w2_n = rk_q[63:32]  ^ w1_n;
    w3_n = rk_q[31:0]   ^ w2_n;
  end

  always_comb begin
    state_d = state_q;
    start_d = start;
    rk_d    = rk_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    fin_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXPAND;
          rk_d    = key;
          idx_d   = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EXPAND: begin
        if (last) begin
          // round_key/round_idx intentionally hold until the next accept.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rk_d    = {w0_n, w1_n, w2_n, w3_n};
          idx_d   = idx_q + 4'd1;
          valid_d = 1'b1;
          fin_d   = (idx_q == 4'(NROUNDS - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign round_key = rk_q;
  assign round_idx = idx_q;
  assign rk_valid  = valid_q;
  assign finish    = fin_q;
  assign busy      = busy_q;

`ifdef AES_KEY_STORE_EN
  block_t store_q [NROUNDS+1];
  block_t store_d [NROUNDS+1];

  // Each emitted key is captured while it is presented on round_key.
  always_comb begin
    store_d = store_q;
    if (valid_q) begin
      store_d[idx_q] = rk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= NROUNDS; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_idx <= 4'(NROUNDS)) ? store_q[rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         finish;
  logic         busy;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc [1:10];
  logic [127:0] model_rk [11];
  logic [127:0] got [11];

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .finish    (finish),
    .busy      (busy),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_tables();
    logic [7:0] inv [256];
    logic [7:0] b;
    inv[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      inv[a] = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) inv[a] = 8'(c);
      end
    end
    for (int a = 0; a < 256; a++) begin
      b = inv[a];
      sb[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    rc[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One expansion: start held `hold` cycles; optional extra start pulse at
  // round index `glitch` (-1 for none); key scrambled every cycle after accept.
  task automatic run(input logic [127:0] k, input int hold, input int glitch, input string tag);
    int nvalid = 0;
    int nfin   = 0;
    logic want;
    build_model(k);
    key   = k;
    start = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      want = (c + 1 < hold);
      if (rk_valid) begin
        if (nvalid < 11) got[nvalid] = round_key;
        chk({tag, "_key"}, round_key, model_rk[nvalid % 11]);
        chk({tag, "_idx"}, round_idx, nvalid[3:0]);
        chk({tag, "_finish"}, finish, (nvalid == 10));
        chk({tag, "_busy"}, busy, 1'b1);
        if (glitch >= 0 && int'(round_idx) == glitch) want = 1'b1;
        nvalid++;
      end
      if (finish) nfin++;
      start = want;
      key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 1'b0;
    chk({tag, "_nvalid"}, nvalid, 11);
    chk({tag, "_nfinish"}, nfin, 1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_valid_end"}, rk_valid, 1'b0);
    chk({tag, "_hold_key"}, round_key, model_rk[10]);
    chk({tag, "_hold_idx"}, round_idx, 4'd10);
  endtask

  initial begin
    bit found;
    rst    = 1'b0;
    start  = 1'b0;
    key    = '0;
    rd_idx = 4'd0;
    build_tables();

    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_round_key", round_key, 128'h0);
    chk("rst_round_idx", round_idx, 4'd0);
    chk("rst_rk_valid", rk_valid, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_key", rd_key, 128'h0);

    run(FipsKey, 1, -1, "fips");
    chk("fips_k0", got[0], FipsKey);
    chk("fips_k1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_k2", got[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("fips_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd1;
    #1;
    chk("store_rd1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd10;
    #1;
    chk("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd15;
    #1;
    chk("store_rd15", rd_key, 128'h0);
`else
    rd_idx = 4'd1;
    #1;
    chk("rd_key_tied", rd_key, 128'h0);
`endif
    rd_idx = 4'd0;

    run(128'h0, 1, -1, "zero");
    chk("zero_k1", got[1], 128'h62636363626363636263636362636363);
    chk("zero_k10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run(FipsKey, 3, -1, "hold");
    run(FipsKey, 1, 5, "glitch");
    chk("glitch_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Abort mid-expansion with reset.
    key   = FipsKey;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (rk_valid && round_idx == 4'd4) found = 1'b1;
      else tick();
    end
    chk("abort_reach_idx4", found, 1'b1);
    rst = 1'b0;
    tick();
    chk("abort_valid", rk_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_finish", finish, 1'b0);
    rst = 1'b1;
    tick();
    chk("abort_idle_valid", rk_valid, 1'b0);
    run(FipsKey, 1, -1, "after_abort");

    for (int r = 0; r < 4; r++) begin
      run({$urandom, $urandom, $urandom, $urandom}, 1 + (r % 2), -1, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
